lightbike_input_arbiter: RTL
============================

# lightbike_input_arbiter

Converts the PS/2 keyboard controller's decoded key-event stream into two per-player direction command queues for the lightbike game. Both players share one keyboard: player 1 uses W/A/S/D, player 2 uses the extended arrow keys. Each player's turn requests are buffered and released at most one per game tick. This keeps bursts of fast keypresses within a single game step from being lost or merged. The block sits between the keyboard controller and the game-state engine.

## Interface
- FIFO_DEPTH, 4, entries per player queue; power of two, 2..16
- c50  in  1  system clock (50 MHz)
- reset_all  in  1  asynchronous active-low reset
- key_valid  in  1  one-cycle strobe: one completed scan code
- key_code  in  9  {extended, code[7:0]}; extended = E0 prefix seen
- key_break  in  1  qualifies key_valid: 1 = release (F0), 0 = press
- tick  in  1  one-cycle game-step strobe
- enable  in  1  game running; 0 flushes queues
- p1_dir  out  2  player 1 current direction
- p2_dir  out  2  player 2 current direction
- p1_turn  out  1  one-cycle pulse: p1_dir just updated from queue
- p2_turn  out  1  one-cycle pulse: p2_dir just updated from queue
- p1_ovf  out  1  sticky: player 1 press dropped because queue full
- p2_ovf  out  1  sticky: player 2 press dropped because queue full

## Operation
- Direction encoding: 00 up, 01 right, 10 down, 11 left. Opposite direction = dir ^ 2'b10.
- Key map, player 1:
  - 0x01D up, 0x023 right, 0x01B down, 0x01C left.
- Key map, player 2:
  - 0x175 up, 0x174 right, 0x172 down, 0x16B left.
- Unmapped codes are ignored.
- Break events (key_break=1) are always ignored.
- Reference direction per player = last enqueued entry if the queue is non-empty, else the current pN_dir.
- Press handling on key_valid & !key_break & enable & mapped:
  - new == reference: discarded (typematic repeat).
  - new == opposite(reference): discarded (see Configuration).
  - queue full and no pop this cycle: discarded, pN_ovf set.
  - otherwise: enqueued.
- On tick & enable, each player independently: if its queue is non-empty, pop the head into pN_dir and pulse pN_turn.
- Push and pop in the same cycle:
  - Both are performed.
  - The reference direction and full status use pre-cycle state.
  - A full queue with a simultaneous pop accepts the push; count is unchanged.
- enable=0:
  - Both queues are cleared.
  - Pushes and pops are blocked.
  - pN_ovf is cleared.
  - pN_dir holds its value.
- Reset values:
  - p1_dir=01 (right), p2_dir=11 (left).
  - p1_turn, p2_turn, p1_ovf, p2_ovf = 0.
  - Queues empty.
- Reset mid-operation: everything returns to reset values asynchronously. Queued entries are lost.

## Timing
- All outputs are registered.
- Tick in cycle n → pN_dir is updated and pN_turn is high in cycle n+1, for exactly one cycle.
- A push in cycle n can be popped by a tick in cycle n+1 at the earliest. A tick in the same cycle as the push pops the prior head, or nothing if the queue was empty.
- Back-to-back ticks pop one entry each.
- enable falling: the queues are empty from the next cycle.
- Event throughput: one key_valid per cycle.

## Configuration
- LIGHTBIKE_REVERSE_FILTER_EN defined: 180° reversals relative to the reference direction are discarded, as in Operation.
- Not defined: reversals are enqueued like any other turn. The game engine is then responsible for treating them as self-collision.
- Repeat (same-direction) filtering is unaffected by the macro.

## Structure
- Shared package lightbike_pkg holds:
  - Direction encoding constants DIR_UP/RIGHT/DOWN/LEFT.
  - The 9-bit scan-code constants for both key maps.
  - Reset directions P1_DIR_RST / P2_DIR_RST.
- Sub-module dir_fifo is instantiated once per player. It contains:
  - FIFO_DEPTH x 2-bit storage with wrap-around read/write pointers.
  - An occupancy count.
  - Outputs head, tail (last written), empty, full.
  - Inputs push, pop, flush.
- The top level does key decode, filtering, and the output registers.

## Test plan
- Reset, then tick with no keys → p1_dir=01, p2_dir=11, no turn pulses, ovf=0.
- P1 press 0x01D then 0x01C, then 2 ticks:
  - First tick → p1_dir=00 with p1_turn.
  - Second tick → p1_dir=11 with p1_turn.
  - p2 unchanged throughout.
- P2 press 0x16B (same as current), 0x174 (reverse), then tick:
  - With macro: both discarded, no p2_turn.
  - Without macro: tick → p2_dir=01.
- P1 presses 00, 11, 10, 01, 00 alternating with no tick (FIFO_DEPTH=4) → 5th dropped, p1_ovf=1. Four ticks yield 00, 11, 10, 01.
- Queue full, press and tick in the same cycle → push accepted, head popped, count stays 4, ovf stays 0.
- Queue holding 2 entries, then enable=0 for one cycle, then tick → no turn, dir held, ovf cleared. Repeat with reset_all pulsed mid-queue → reset values.

Source files
------------

// File: rtl/lightbike_pkg.sv
// Shared lightbike definitions: direction encoding, keyboard scan codes and reset directions.
package lightbike_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'b00;
  localparam dir_t DIR_RIGHT = 2'b01;
  localparam dir_t DIR_DOWN  = 2'b10;
  localparam dir_t DIR_LEFT  = 2'b11;

  // {extended, code}: player 1 on W/D/S/A, player 2 on the E0-prefixed arrows
  localparam logic [8:0] KEY_P1_UP    = 9'h01D;
  localparam logic [8:0] KEY_P1_RIGHT = 9'h023;
  localparam logic [8:0] KEY_P1_DOWN  = 9'h01B;
  localparam logic [8:0] KEY_P1_LEFT  = 9'h01C;
  localparam logic [8:0] KEY_P2_UP    = 9'h175;
  localparam logic [8:0] KEY_P2_RIGHT = 9'h174;
  localparam logic [8:0] KEY_P2_DOWN  = 9'h172;
  localparam logic [8:0] KEY_P2_LEFT  = 9'h16B;

  localparam dir_t P1_DIR_RST = DIR_RIGHT;
  localparam dir_t P2_DIR_RST = DIR_LEFT;

  function automatic dir_t opposite(input dir_t d);
    return d ^ 2'b10;
  endfunction

endpackage

// File: rtl/dir_fifo.sv
// Per-player direction queue: DEPTH x 2-bit ring buffer with occupancy count.
// Pops on an empty queue are ignored; a push into a full queue only lands when a pop frees the slot.
module dir_fifo
  import lightbike_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [1:0] din,
  output logic [1:0] head,
  output logic [1:0] tail,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(DEPTH);

  logic [1:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign empty     = (count_r == (AW+1)'(0));
  assign full      = (count_r == (AW+1)'(DEPTH));
  assign head      = mem_r[rd_ptr_r];
  assign tail      = mem_r[wr_ptr_r - AW'(1)];
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);

  // Storage, power-of-two pointers wrap naturally; flush drops contents without touching storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= 2'b00;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/lightbike_input_arbiter.sv
// Key-event to per-player direction queue arbiter for the lightbike game.
// Define LIGHTBIKE_REVERSE_FILTER_EN to drop 180-degree reversals at enqueue time.
module lightbike_input_arbiter
  import lightbike_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       c50,
  input  logic       reset_all,
  input  logic       key_valid,
  input  logic [8:0] key_code,
  input  logic       key_break,
  input  logic       tick,
  input  logic       enable,
  output logic [1:0] p1_dir,
  output logic [1:0] p2_dir,
  output logic       p1_turn,
  output logic       p2_turn,
  output logic       p1_ovf,
  output logic       p2_ovf
);

  logic       hit_s    [2];
  dir_t       new_s    [2];
  dir_t       ref_s    [2];
  logic       ok_s     [2];
  logic       push_s   [2];
  logic       pop_s    [2];
  logic       drop_s   [2];
  dir_t       head_s   [2];
  dir_t       tail_s   [2];
  logic       empty_s  [2];
  logic       full_s   [2];
  dir_t       dir_r    [2];
  logic       turn_r   [2];
  logic       ovf_r    [2];

  // Scan-code decode; index 0 is player 1, index 1 is player 2
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      hit_s[i] = 1'b0;
      new_s[i] = DIR_UP;
    end
    if (key_valid && !key_break && enable) begin
      case (key_code)
        KEY_P1_UP:    begin hit_s[0] = 1'b1; new_s[0] = DIR_UP;    end
        KEY_P1_RIGHT: begin hit_s[0] = 1'b1; new_s[0] = DIR_RIGHT; end
        KEY_P1_DOWN:  begin hit_s[0] = 1'b1; new_s[0] = DIR_DOWN;  end
        KEY_P1_LEFT:  begin hit_s[0] = 1'b1; new_s[0] = DIR_LEFT;  end
        KEY_P2_UP:    begin hit_s[1] = 1'b1; new_s[1] = DIR_UP;    end
        KEY_P2_RIGHT: begin hit_s[1] = 1'b1; new_s[1] = DIR_RIGHT; end
        KEY_P2_DOWN:  begin hit_s[1] = 1'b1; new_s[1] = DIR_DOWN;  end
        KEY_P2_LEFT:  begin hit_s[1] = 1'b1; new_s[1] = DIR_LEFT;  end
        default: begin
          hit_s[0] = 1'b0;
          hit_s[1] = 1'b0;
        end
      endcase
    end else begin
      hit_s[0] = 1'b0;
      hit_s[1] = 1'b0;
    end
  end

  // Filtering against the reference direction, all decisions on pre-cycle queue state
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      ref_s[i] = empty_s[i] ? dir_r[i] : tail_s[i];
      pop_s[i] = tick & enable & ~empty_s[i];
`ifdef LIGHTBIKE_REVERSE_FILTER_EN
      ok_s[i]  = (new_s[i] != ref_s[i]) && (new_s[i] != opposite(ref_s[i]));
`else
      ok_s[i]  = (new_s[i] != ref_s[i]);
`endif
      push_s[i] = hit_s[i] & ok_s[i] & (~full_s[i] | pop_s[i]);
      drop_s[i] = hit_s[i] & ok_s[i] & full_s[i] & ~pop_s[i];
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    dir_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (c50),
      .rst_n (reset_all),
      .push  (push_s[g]),
      .pop   (pop_s[g]),
      .flush (~enable),
      .din   (new_s[g]),
      .head  (head_s[g]),
      .tail  (tail_s[g]),
      .empty (empty_s[g]),
      .full  (full_s[g])
    );
  end

  // Output registers: direction loads on pop, turn pulses, sticky overflow cleared by enable low
  always_ff @(posedge c50 or negedge reset_all) begin
    if (!reset_all) begin
      dir_r[0]  <= P1_DIR_RST;
      dir_r[1]  <= P2_DIR_RST;
      turn_r[0] <= 1'b0;
      turn_r[1] <= 1'b0;
      ovf_r[0]  <= 1'b0;
      ovf_r[1]  <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        turn_r[i] <= pop_s[i];
        if (pop_s[i]) dir_r[i] <= head_s[i];
        if (!enable) begin
          ovf_r[i] <= 1'b0;
        end else if (drop_s[i]) begin
          ovf_r[i] <= 1'b1;
        end
      end
    end
  end

  assign p1_dir  = dir_r[0];
  assign p2_dir  = dir_r[1];
  assign p1_turn = turn_r[0];
  assign p2_turn = turn_r[1];
  assign p1_ovf  = ovf_r[0];
  assign p2_ovf  = ovf_r[1];

endmodule
